stream_unpack: RTL and testbench

//  Sequential unpacker. Accepts one packed word of CNT elements x NBIT bits on a valid/ready

---
 rtl/bit_pkg.sv | 25 ++
 rtl/stream_unpack.sv | 96 +++++++++
 tb/tb_stream_unpack.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_pkg.sv
// Shared types and helpers for the stream unpacker.
package bit_pkg;

  // Unpacker state: IDLE waits for a word, BUSY is emitting its elements.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } unpack_st_t;

  // Ceiling log2 with a floor of 1, so a single-element index still has one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < n) begin
        r = k + 1;
      end
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_unpack.sv
// Sequential unpacker: takes one packed word of CNT elements of NBIT bits and
// emits them one per beat, element 0 (the MSB slice) first.
module stream_unpack
  import bit_pkg::*;
#(
  parameter int NBIT = 8,
  parameter int CNT  = 8,
  localparam int IW  = clog2_min1(CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NBIT*CNT-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NBIT-1:0]     out_data,
  output logic [IW-1:0]       out_idx,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int W = NBIT * CNT;

  unpack_st_t      r_state;
  logic [W-1:0]    r_buf;
  logic [IW-1:0]   r_idx;

  logic            w_busy;
  logic            w_last;
  logic            w_in_fire;
  logic            w_out_fire;

  // Output decode and handshakes; in_ready in BUSY only opens on the final
  // accepted beat so the next word can load without a bubble.
  always_comb begin
    w_busy     = (r_state == BUSY);
    out_valid  = w_busy;
    out_data   = r_buf[W-1 -: NBIT];
    out_idx    = r_idx;
    w_last     = w_busy && (r_idx == IW'(CNT - 1));
    out_last   = w_last;
    w_out_fire = w_busy & out_ready;
    if (rst) begin
      in_ready = 1'b0;
    end else if (!w_busy) begin
      in_ready = 1'b1;
    end else begin
      in_ready = w_out_fire & w_last;
    end
    w_in_fire = in_valid & in_ready;
  end

  // State, shift buffer and element index; the buffer shifts left so the
  // current element is always the MSB slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_buf   <= in_data;
            r_idx   <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_out_fire) begin
            if (!w_last) begin
              r_buf <= r_buf << NBIT;
              r_idx <= r_idx + IW'(1);
            end else if (w_in_fire) begin
              r_buf   <= in_data;
              r_idx   <= '0;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= BUSY;
          end
        end
        default: begin
          r_state <= IDLE;
          r_buf   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_unpack.sv
// Directed bench for stream_unpack: a CNT=4/NBIT=8 instance and a
// CNT=1/NBIT=16 instance sharing clock and reset.
module tb_stream_unpack;

  logic        clk;
  logic        rst;

  logic [31:0] in_data4;
  logic        in_valid4;
  logic        in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_idx4;
  logic        out_last4;
  logic        out_valid4;
  logic        out_ready4;

  logic [15:0] in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] out_data1;
  logic [0:0]  out_idx1;
  logic        out_last1;
  logic        out_valid1;
  logic        out_ready1;

  int n_cmp;
  int n_err;

  stream_unpack #(.NBIT(8), .CNT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_idx(out_idx4), .out_last(out_last4),
    .out_valid(out_valid4), .out_ready(out_ready4)
  );

  stream_unpack #(.NBIT(16), .CNT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle a little after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full CNT=4 output bundle.
  task automatic chk4(input string tag, input logic v, input logic [7:0] d,
                      input logic [1:0] idx, input logic last, input logic rdy);
    chk({tag, ".valid"}, {31'd0, out_valid4}, {31'd0, v});
    chk({tag, ".data"},  {24'd0, out_data4},  {24'd0, d});
    chk({tag, ".idx"},   {30'd0, out_idx4},   {30'd0, idx});
    chk({tag, ".last"},  {31'd0, out_last4},  {31'd0, last});
    chk({tag, ".in_rdy"},{31'd0, in_ready4},  {31'd0, rdy});
  endtask

  logic [7:0] exp_b [0:7];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_data4 = 32'h5A5A_5A5A; in_valid4 = 1'b1; out_ready4 = 1'b1;
    in_data1 = 16'h5A5A;      in_valid1 = 1'b1; out_ready1 = 1'b1;

    // 1: reset held 3 clocks with in_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_ready", {31'd0, in_ready4}, 32'd0);
      chk("rst.out_valid", {31'd0, out_valid4}, 32'd0);
      chk("rst.out_idx", {30'd0, out_idx4}, 32'd0);
      chk("rst1.in_ready", {31'd0, in_ready1}, 32'd0);
      chk("rst1.out_valid", {31'd0, out_valid1}, 32'd0);
    end
    chk("rst.out_last", {31'd0, out_last4}, 32'd0);
    chk("rst.out_data", {24'd0, out_data4}, 32'd0);
    chk("rst1.out_last", {31'd0, out_last1}, 32'd0);
    in_valid4 = 1'b0;
    in_valid1 = 1'b0;
    rst = 1'b0;
    tick();
    chk4("idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // 2: single word, full rate
    in_data4 = 32'hA1B2_C3D4; in_valid4 = 1'b1;
    #1;
    chk("t2.accept", {31'd0, in_ready4}, 32'd1);
    tick();
    in_valid4 = 1'b0; in_data4 = 32'hFFFF_FFFF;
    #1;
    chk4("t2.b0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
    tick(); #1;
    chk4("t2.b1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
    tick(); #1;
    chk4("t2.b2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
    tick(); #1;
    chk4("t2.b3", 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1);
    tick(); #1;
    chk("t2.idle", {31'd0, out_valid4}, 32'd0);

    // 3: back-to-back words, no bubble
    for (int i = 0; i < 8; i++) exp_b[i] = 8'(i + 1);
    in_data4 = 32'h0102_0304; in_valid4 = 1'b1;
    tick();
    in_data4 = 32'h0506_0708;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid4 = 1'b0;
      #1;
      chk4($sformatf("t3.b%0d", i), 1'b1, exp_b[i], 2'(i % 4),
           (i % 4) == 3, (i % 4) == 3);
      tick();
    end
    #1;
    chk("t3.idle", {31'd0, out_valid4}, 32'd0);

    // 4: backpressure after B2
    in_data4 = 32'hA1B2_C3D4; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    #1;
    chk4("t4.b0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
    tick();
    out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = 32'h9999_9999;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk4($sformatf("t4.hold%0d", i), 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
      tick();
    end
    out_ready4 = 1'b1; in_valid4 = 1'b0;
    #1;
    chk4("t4.b1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
    tick(); #1;
    chk4("t4.b2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
    tick(); #1;
    chk4("t4.b3", 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1);
    tick(); #1;
    chk("t4.idle", {31'd0, out_valid4}, 32'd0);

    // 5: reset mid-word
    in_data4 = 32'hDEAD_BEEF; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    #1;
    chk4("t5.b0", 1'b1, 8'hDE, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5.rst_in_ready", {31'd0, in_ready4}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5.drop", {31'd0, out_valid4}, 32'd0);
    chk("t5.idx", {30'd0, out_idx4}, 32'd0);
    tick(); #1;
    chk("t5.quiet", {31'd0, out_valid4}, 32'd0);
    in_data4 = 32'h1122_3344; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    #1;
    chk4("t5.n0", 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    tick(); #1;
    chk4("t5.n1", 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chk("t5.idle", {31'd0, out_valid4}, 32'd0);

    // 6: CNT=1 register slice at full throughput
    in_data1 = 16'h1234; in_valid1 = 1'b1;
    tick();
    in_data1 = 16'hABCD;
    #1;
    chk("t6.v0", {31'd0, out_valid1}, 32'd1);
    chk("t6.d0", {16'd0, out_data1}, 32'h1234);
    chk("t6.i0", {31'd0, out_idx1}, 32'd0);
    chk("t6.l0", {31'd0, out_last1}, 32'd1);
    chk("t6.r0", {31'd0, in_ready1}, 32'd1);
    tick();
    in_valid1 = 1'b0;
    #1;
    chk("t6.v1", {31'd0, out_valid1}, 32'd1);
    chk("t6.d1", {16'd0, out_data1}, 32'hABCD);
    chk("t6.i1", {31'd0, out_idx1}, 32'd0);
    chk("t6.l1", {31'd0, out_last1}, 32'd1);
    tick(); #1;
    chk("t6.idle", {31'd0, out_valid1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
